rx_sink: RTL

Receive-side drain for the two destination FIFOs (D0, D1) at the far end of the TX path. Watches both FIFO empty flags, issues single-cycle POP_D0/POP_D1 under round-robin arbitration, captures the 6-bit word one cycle later, and presents it on a valid/ready output port tagged with its source destination. Also keeps per-destination received-word counters for the bench scoreboard and the top-level status.

---
 rtl/rx_sink_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 32 +++
 rtl/rx_sink.sv | 129 ++++++++++++
 3 files changed

// File: rtl/rx_sink_pkg.sv
// Shared types and constants for the receive-side FIFO drain.
// Destination encoding matches the OUT_DEST port: 0 = D0, 1 = D1.
package rx_sink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_POP     = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  localparam int   DATA_W_DEF = 6;
  localparam logic DEST_D0    = 1'b0;
  localparam logic DEST_D1    = 1'b1;

  // One-hot grant to destination index.
  function automatic logic gnt_to_dest(input logic [1:0] gnt);
    return gnt[1] ? DEST_D1 : DEST_D0;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; owns the priority pointer.
// A lone requester always wins; the pointer then moves away from whoever won.
module rr_arb2
  import rx_sink_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr_q;

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = (ptr_q == DEST_D1) ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= DEST_D0;
    end else if (advance && (gnt != 2'b00)) begin
      ptr_q <= ~gnt_to_dest(gnt);
    end
  end

endmodule

// File: rtl/rx_sink.sv
// Drains the D0/D1 destination FIFOs under round-robin arbitration and presents
// each word on a valid/ready port tagged with its source, counting deliveries.
module rx_sink
  import rx_sink_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              init,
  input  logic              D0_EMPTY,
  input  logic              D1_EMPTY,
  input  logic [DATA_W-1:0] D0_DATA_OUT,
  input  logic [DATA_W-1:0] D1_DATA_OUT,
  output logic              POP_D0,
  output logic              POP_D1,
  input  logic              OUT_READY,
  output logic              OUT_VALID,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_DEST,
  output logic [CNT_W-1:0]  CNT_D0,
  output logic [CNT_W-1:0]  CNT_D1,
  output logic              IDLE
);

  function automatic logic [CNT_W-1:0] cnt_wrap_inc(input logic [CNT_W-1:0] c);
    return c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t            state_q, state_d;
  logic              rst_all;
  logic [1:0]        req, gnt;
  logic              pop_ok, start, consume;
  logic              pop_d0_d, pop_d1_d;
  logic              pop_d0_p1, pop_d1_p1, dest_p1;
  logic              vld_p2, dest_p2;
  logic [DATA_W-1:0] data_p2;
  logic [CNT_W-1:0]  cnt_d0_q, cnt_d1_q;
  logic              idle_q;

  assign rst_all = RESET | init;
  assign req     = {~D1_EMPTY, ~D0_EMPTY};
  // Only one pop in flight, and only when the output slot is free or draining.
  assign pop_ok  = (state_q == ST_IDLE) && (!vld_p2 || OUT_READY);
  assign start   = pop_ok && (req != 2'b00);
  assign consume = vld_p2 && OUT_READY;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst_all),
    .req     (req),
    .advance (start),
    .gnt     (gnt)
  );

  always_comb begin
    state_d  = state_q;
    pop_d0_d = 1'b0;
    pop_d1_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_POP;
          pop_d0_d = gnt[0];
          pop_d1_d = gnt[1];
        end
      end
      ST_POP:     state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // p1: pop strobe and granted destination
  always_ff @(posedge clk) begin
    if (rst_all) begin
      state_q   <= ST_IDLE;
      pop_d0_p1 <= 1'b0;
      pop_d1_p1 <= 1'b0;
      dest_p1   <= DEST_D0;
      idle_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      pop_d0_p1 <= pop_d0_d;
      pop_d1_p1 <= pop_d1_d;
      if (start) begin
        dest_p1 <= gnt_to_dest(gnt);
      end
      idle_q    <= (state_d == ST_IDLE);
    end
  end

  // p2: captured word, output handshake and delivery counters
  always_ff @(posedge clk) begin
    if (rst_all) begin
      vld_p2   <= 1'b0;
      data_p2  <= '0;
      dest_p2  <= DEST_D0;
      cnt_d0_q <= '0;
      cnt_d1_q <= '0;
    end else begin
      if (state_q == ST_CAPTURE) begin
        vld_p2  <= 1'b1;
        data_p2 <= (dest_p1 == DEST_D1) ? D1_DATA_OUT : D0_DATA_OUT;
        dest_p2 <= dest_p1;
      end else if (consume) begin
        vld_p2 <= 1'b0;
      end
      if (consume) begin
        if (dest_p2 == DEST_D1) begin
          cnt_d1_q <= cnt_wrap_inc(cnt_d1_q);
        end else begin
          cnt_d0_q <= cnt_wrap_inc(cnt_d0_q);
        end
      end
    end
  end

  assign POP_D0    = pop_d0_p1;
  assign POP_D1    = pop_d1_p1;
  assign OUT_VALID = vld_p2;
  assign OUT_DATA  = data_p2;
  assign OUT_DEST  = dest_p2;
  assign CNT_D0    = cnt_d0_q;
  assign CNT_D1    = cnt_d1_q;
  assign IDLE      = idle_q;

endmodule
